delay_arbiter: RTL and testbench

//   Shares one fixed-depth register delay pipeline between NUM_REQ requesters.
//   A round-robin arbiter grants one requester per cycle. The granted value enters
//   the pipeline tagged with the requester ID.

---
 rtl/delay_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/delay_arbiter.sv | 120 ++++++++++++
 tb/tb_delay_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the shared delay pipeline arbiter.
package delay_arb_pkg;

  // Default configuration for the arbiter and its pipeline
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 2;

  // Width of a requester ID; never narrower than one bit
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(NUM_REQ_DEF);

  // One pipeline stage for the default configuration
  typedef struct packed {
    logic                  valid;
    logic [ID_W_DEF-1:0]   id;
    logic [DATA_W_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches ptr, ptr+1, ... wrapping mod NUM_REQ.
// The pointer register itself is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Requester index examined at each search offset, and its request bit
  logic [ID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      // ptr + offset fits in ID_W+1 bits, so one conditional subtract wraps it
      assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ?
                            ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // First requesting candidate in search order wins; nothing is granted when disabled
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && cand_req[i]) begin
        valid = 1'b1;
        id    = cand_idx[i];
      end
    end
    if (!en) begin
      valid = 1'b0;
      id    = '0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = valid && (id == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/delay_arbiter.sv
// Shares one fixed-depth delay pipeline between NUM_REQ requesters. A round-robin
// winner enters the pipeline tagged with its ID and returns DEPTH cycles later on a
// common response bus with a one-hot valid steered back to the originator.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic                      busy_o
);

  // Stage layout sized for this instance's parameters
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } pipe_stage_t;

  logic [ID_W-1:0]   ptr_reg;
  logic [ID_W-1:0]   ptr_next;
  pipe_stage_t       stage_reg [DEPTH];
  pipe_stage_t       stage0_next;
  pipe_stage_t       last_stage;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_valid;
  logic              arb_en;
  logic [DATA_W-1:0] lane_data [NUM_REQ];
  logic [DEPTH-1:0]  stage_valid;

  // Grants are suppressed while held in reset so every output reads 0
  assign arb_en = en_i & rst_ni;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_i),
    .ptr   (ptr_reg),
    .en    (arb_en),
    .gnt   (gnt_o),
    .id    (gnt_id),
    .valid (gnt_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi] = data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Entry for stage 0: the granted payload, or an all-zero bubble
  always_comb begin
    stage0_next = '0;
    if (gnt_valid) begin
      stage0_next.valid = 1'b1;
      stage0_next.id    = gnt_id;
      stage0_next.data  = lane_data[gnt_id];
    end
  end

  // Pointer moves to the requester after the winner; unchanged without a grant
  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_valid) begin
      ptr_next = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Round-robin pointer register, frozen while the pipeline is held
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= '0;
    end else if (en_i) begin
      ptr_reg <= ptr_next;
    end
  end

  // Delay pipeline: shifts one stage per enabled edge, holds otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_reg[k] <= '0;
      end
    end else if (en_i) begin
      stage_reg[0] <= stage0_next;
      for (int k = 1; k < DEPTH; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end
  end

  assign last_stage = stage_reg[DEPTH-1];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      // A waiting entry is only delivered on an enabled cycle, so it is seen once
      assign rsp_valid_o[gi] = last_stage.valid && en_i && (last_stage.id == ID_W'(gi));
    end
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign stage_valid[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign rsp_data_o = last_stage.valid ? last_stage.data : '0;
  assign rsp_id_o   = last_stage.valid ? last_stage.id   : '0;
  assign busy_o     = |stage_valid;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter (NUM_REQ=4, DATA_W=8, DEPTH=2): one continuous
// table of per-cycle vectors plus a hand-written reset-while-busy sequence.
module tb_delay_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        en_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic [1:0]  rsp_id_o;
  logic        busy_o;

  int n_cmp;
  int n_bad;

  delay_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .DEPTH   (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .req_i       (req_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic        en;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [7:0]  rd;
    logic [1:0]  rid;
    logic        busy;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [3:0] g, input logic [3:0] rv,
                           input logic [7:0] rd, input logic [1:0] rid, input logic b);
    check("gnt",       idx, 32'(gnt_o),       32'(g));
    check("rsp_valid", idx, 32'(rsp_valid_o), 32'(rv));
    check("rsp_data",  idx, 32'(rsp_data_o),  32'(rd));
    check("rsp_id",    idx, 32'(rsp_id_o),    32'(rid));
    check("busy",      idx, 32'(busy_o),      32'(b));
  endtask

  initial begin
    logic [31:0] dl;  // lane r = 8'h10 + r
    logic [31:0] da;  // lane 2 = A5
    logic [31:0] d5;  // lane 1 = 55
    dl = 32'h13121110;
    da = 32'h00A50000;
    d5 = 32'h00005500;
    n_cmp = 0;
    n_bad = 0;

    //                req      en    data gnt      rv       rd     rid    busy
    // single request from r2, returns 2 cycles later
    vecs[0]  = '{4'b0100, 1'b1, da, 4'b0100, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 1'b1, da, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[2]  = '{4'b0000, 1'b1, da, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1};
    vecs[3]  = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    // wrap: ptr=3, r3 then r0
    vecs[4]  = '{4'b1001, 1'b1, dl, 4'b1000, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[5]  = '{4'b0001, 1'b1, dl, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, dl, 4'b0000, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[7]  = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0001, 8'h10, 2'd0, 1'b1};
    // bring ptr back to 0, then all requesting for 8 cycles
    vecs[8]  = '{4'b1000, 1'b1, dl, 4'b1000, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, dl, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, dl, 4'b0010, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[11] = '{4'b1111, 1'b1, dl, 4'b0100, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[12] = '{4'b1111, 1'b1, dl, 4'b1000, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[13] = '{4'b1111, 1'b1, dl, 4'b0001, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[14] = '{4'b1111, 1'b1, dl, 4'b0010, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[15] = '{4'b1111, 1'b1, dl, 4'b0100, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[16] = '{4'b1111, 1'b1, dl, 4'b1000, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[17] = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[18] = '{4'b0000, 1'b1, dl, 4'b0000, 4'b1000, 8'h13, 2'd3, 1'b1};
    // bubbles: alternate request / idle
    vecs[19] = '{4'b0010, 1'b1, dl, 4'b0010, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[20] = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[21] = '{4'b0100, 1'b1, dl, 4'b0100, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[22] = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[23] = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[24] = '{4'b0000, 1'b1, dl, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    // stall: r1 sends 55, en_i low for 3 cycles at the response cycle
    vecs[25] = '{4'b0010, 1'b1, d5, 4'b0010, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[26] = '{4'b0000, 1'b1, d5, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[27] = '{4'b0000, 1'b0, d5, 4'b0000, 4'b0000, 8'h55, 2'd1, 1'b1};
    vecs[28] = '{4'b0100, 1'b0, d5, 4'b0000, 4'b0000, 8'h55, 2'd1, 1'b1};
    vecs[29] = '{4'b0100, 1'b0, d5, 4'b0000, 4'b0000, 8'h55, 2'd1, 1'b1};
    vecs[30] = '{4'b0100, 1'b1, d5, 4'b0100, 4'b0010, 8'h55, 2'd1, 1'b1};
    vecs[31] = '{4'b0000, 1'b1, d5, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b1};
    vecs[32] = '{4'b0000, 1'b1, d5, 4'b0000, 4'b0100, 8'h00, 2'd2, 1'b1};
    vecs[33] = '{4'b0000, 1'b1, d5, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};

    // Reset state with requests pending: everything must read 0
    rst_ni = 1'b0;
    en_i   = 1'b1;
    req_i  = 4'b1111;
    data_i = dl;
    #2;
    check_all(-1, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Table: inputs driven just after the edge, outputs sampled mid-cycle
    for (int i = 0; i < NV; i++) begin
      req_i  = vecs[i].req;
      en_i   = vecs[i].en;
      data_i = vecs[i].data;
      #2;
      $display("vec %0d: req=%b en=%b gnt=%b rsp_valid=%b rsp_data=%h rsp_id=%0d busy=%b",
               i, req_i, en_i, gnt_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o);
      check_all(i, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rid, vecs[i].busy);
      @(posedge clk_i);
      #1;
    end

    // Reset with two entries in flight (ptr is 3 here)
    en_i   = 1'b1;
    data_i = dl;
    req_i  = 4'b0001;
    #2;
    check("rst_seq_gnt", 0, 32'(gnt_o), 32'h1);
    @(posedge clk_i);
    #1;
    req_i = 4'b0010;
    #2;
    check("rst_seq_gnt", 1, 32'(gnt_o), 32'h2);
    @(posedge clk_i);
    #1;
    check("rst_seq_busy", 2, 32'(busy_o), 32'h1);
    req_i  = 4'b1111;
    rst_ni = 1'b0;
    #1;
    $display("reset asserted: gnt=%b rsp_valid=%b rsp_data=%h rsp_id=%0d busy=%b",
             gnt_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o);
    check_all(100, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    req_i  = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #2;
      $display("post-reset cycle %0d: rsp_valid=%b busy=%b", c, rsp_valid_o, busy_o);
      check("post_rst_rsp_valid", c, 32'(rsp_valid_o), 32'h0);
      check("post_rst_busy",      c, 32'(busy_o),      32'h0);
      @(posedge clk_i);
      #1;
    end
    // Pointer must be back at 0
    req_i = 4'b1111;
    #2;
    $display("post-reset grant: req=%b gnt=%b", req_i, gnt_o);
    check("post_rst_gnt", 0, 32'(gnt_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
